reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter and storage controller for a bank of 32-bit enabled registers shared by several requesters. Each requester presents a valid/ready write request (address, data, optional lock). The block grants at most one write per cycle, commits it to the addressed register and exposes a combinational read port. It sits between the datapath sequencers and the shared register bank.

## Interface
- NREQ, 3, number of requesters (2..8)
- NREG, 8, number of 32-bit registers
- W, 32, data width
- AW, $clog2(NREG), address width
- CLOCK_50  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all registers and lock
- req_valid  in  NREQ  write request per requester
- req_lock  in  NREQ  requester asks to keep ownership after this write
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_data  in  NREQ*W  packed data, requester i at [i*W +: W]
- req_ready  out  NREQ  one-hot grant, combinational
- rd_addr  in  AW  read address
- rd_data  out  W  combinational read of the register bank
- locked  out  1  lock FSM is in LOCKED
- owner  out  3  current or last lock owner index
- wr_count  out  16  committed writes, saturates at 16'hFFFF

## Operation
- Reset low: all registers 0, ptr=0, state IDLE, owner=0, locked=0, wr_count=0. Outputs reach these values immediately, independent of CLOCK_50.
- A write commits on a rising edge when req_valid[i] & req_ready[i]. The addressed register takes req_data[i].
- IDLE grant: the first i with req_valid[i], searched circularly from ptr. No valid requester gives req_ready=0.
- After a commit by requester g, ptr = (g+1) mod NREQ. Without a commit, ptr holds.
- FSM IDLE -> LOCKED when the committed write has req_lock[g]=1; owner=g.
- In LOCKED only the owner is granted, whenever it is valid. Other requesters see ready=0 even when the owner is idle. ptr holds.
- LOCKED -> IDLE when the owner commits with req_lock=0. ptr = (owner+1) mod NREQ.
- clear=1: req_ready=0 that cycle, no commit. All registers 0, state IDLE, ptr holds, wr_count=0. clear wins over every request.
- Address >= NREG: the handshake completes and wr_count increments, but no register changes.
- rd_data = reg[rd_addr]. A write on edge k is visible after edge k, with no bypass. rd_addr >= NREG reads 0.
- wr_count increments on each commit and saturates at 16'hFFFF.

## Timing
- Grant latency 0: ready is combinational from valid, ptr and state. Write latency is 1 edge.
- Requesters hold valid, addr, data and lock stable until ready. valid must not depend on ready.
- Reset asserted mid-lock or mid-request returns to reset state at once. The first grant after release is to requester 0 if it is valid.
- Throughput: one write per cycle sustained. With all requesters valid and no lock, grants rotate 0,1,2,0,...

## Structure
- Shared package holds: FSM state encoding (IDLE=0, LOCKED=1), default NREQ/NREG/W, and the function next_ptr(g, NREQ).
- Sub-module rr_arbiter: inputs valid, ptr and a mask; output one-hot grant. It is purely combinational.
- The top level holds the register array, ptr, FSM, wr_count and read mux.

## Test plan
- Reset=0 then 1, write by req0 (addr 2, data 1) -> rd_addr=2 gives 1 the next cycle; wr_count=1.
- All three valid every cycle, addresses 0,1,2, data 11,20,1000 -> grant order 0,1,2,0; each register holds its requester's data; wr_count increments by one per cycle.
- req1 writes with lock=1, then req0 and req2 stay valid for 3 cycles while req1 writes 100 with lock=0 on cycle 3 -> req0/req2 ready=0 for 3 cycles, locked=1, owner=1; then IDLE and req2 is granted next.
- clear=1 with req0 valid -> ready=0, no commit, all rd_data=0, wr_count=0, locked=0.
- Reset asserted between edges during LOCKED -> locked=0, wr_count=0 and registers 0 immediately; req2 valid alone is granted after release.
- Write to address 9 with NREG=8 -> ready=1 and wr_count increments; all registers unchanged; rd_addr=9 reads 0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter.
// Holds the lock FSM encoding, default sizing and the round-robin pointer step.
// Pure declarations; no logic, no latency, no flow control.
package reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int DEF_NREQ = 3;
  localparam int DEF_NREG = 8;
  localparam int DEF_W    = 32;

  // Pointer step after a commit by requester g: (g + 1) mod nreq.
  function automatic logic [2:0] next_ptr(input logic [2:0] g, input int nreq);
    if (int'(g) >= nreq - 1) begin
      return 3'd0;
    end
    return g + 3'd1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-request and read bus between the sequencers and the register bank.
// req_* carry one valid/ready write channel per requester; rd_* is a combinational read.
// Backpressure: req_ready is the per-requester grant; requesters hold req_* until ready.
interface reg_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int W    = 32,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      rd_addr;
  logic [W-1:0]       rd_data;

  modport master (
    output req_valid, req_lock, req_addr, req_data, rd_addr,
    input  req_ready, rd_data
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, rd_addr,
    output req_ready, rd_data
  );
endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Round-robin picker: first valid & mask bit searched circularly from ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is all-zero when nothing eligible.
// Ports: valid/mask (NREQ) in, ptr (3) in, grant (NREQ, one-hot or zero) out.
module reg_write_arbiter_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [2:0]      ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr is always < NREQ, so a single wrap suffices.
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && valid[idx] && mask[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter with optional ownership lock over a bank of W-bit registers.
// Latency: grant is combinational (0 cycles); a write is visible on rd_data after 1 edge.
// Backpressure: req_ready low while another requester holds the lock or clear is asserted.
// Ports: CLOCK_50, Reset (async, active-low), clear (sync), bus (slave modport),
//        locked / owner (lock FSM status), wr_count (saturating commit counter).
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG,
  parameter int W    = DEF_W,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  input  logic                 clear,
  reg_write_arbiter_if.slave   bus,
  output logic                 locked,
  output logic [2:0]           owner,
  output logic [15:0]          wr_count
);

  localparam int IW = $clog2(NREG);

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      ptr;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] grant;
  logic            commit;
  logic [2:0]      gidx;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            wr_lock;
  logic            wr_in_range;
  logic            rd_in_range;
  logic [W-1:0]    regs [NREG];

  // Eligibility: clear blocks everyone, lock restricts to the owner.
  always_comb begin
    mask = '0;
    if (!clear) begin
      if (state == ST_LOCKED) begin
        for (int i = 0; i < NREQ; i++) begin
          if (3'(i) == owner) begin
            mask[i] = 1'b1;
          end
        end
      end else begin
        mask = '1;
      end
    end
  end

  reg_write_arbiter_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .mask  (mask),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign commit        = |grant;

  // Select the granted requester's write fields.
  always_comb begin
    gidx    = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx    = 3'(i);
        wr_addr = bus.req_addr[i*AW +: AW];
        wr_data = bus.req_data[i*W +: W];
        wr_lock = bus.req_lock[i];
      end
    end
  end

  assign wr_in_range = (int'(wr_addr) < NREG);
  assign rd_in_range = (int'(bus.rd_addr) < NREG);

  // Lock FSM: state register.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock FSM: next state. Only the owner can commit while locked.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (commit) begin
      case (state)
        ST_IDLE:   if (wr_lock)  state_nxt = ST_LOCKED;
        ST_LOCKED: if (!wr_lock) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Lock FSM: outputs.
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // Owner is latched on lock entry and kept afterwards as "last owner".
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      owner <= '0;
    end else if (commit && state == ST_IDLE && wr_lock) begin
      owner <= gidx;
    end
  end

  // Pointer advances past any idle-state winner and past the owner on unlock;
  // a locked owner re-writing with lock held leaves it alone.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      ptr <= '0;
    end else if (commit && (state == ST_IDLE || !wr_lock)) begin
      ptr <= next_ptr(gidx, NREQ);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      wr_count <= '0;
    end else if (clear) begin
      wr_count <= '0;
    end else if (commit && wr_count != 16'hFFFF) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Out-of-range addresses complete the handshake but touch no register.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (clear) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (commit && wr_in_range) begin
      regs[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  assign bus.rd_data = rd_in_range ? regs[bus.rd_addr[IW-1:0]] : '0;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int NREQ = 3;
  localparam int NREG = 8;
  localparam int W    = 32;
  localparam int AW   = 4;

  logic        CLOCK_50;
  logic        Reset;
  logic        clear;
  logic        locked;
  logic [2:0]  owner;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  reg_write_arbiter_if #(.NREQ(NREQ), .W(W), .AW(AW)) bus ();

  reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W), .AW(AW)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .clear    (clear),
    .bus      (bus),
    .locked   (locked),
    .owner    (owner),
    .wr_count (wr_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NREG];
  int          m_ptr;
  bit          m_locked;
  int          m_owner;
  int          m_cnt;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_regs[r] = '0;
    m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
  endtask

  function automatic logic [2:0] exp_grant();
    if (clear) return 3'b000;
    if (m_locked) return bus.req_valid[m_owner] ? (3'b001 << m_owner) : 3'b000;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (bus.req_valid[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  always @(posedge CLOCK_50 or negedge Reset) begin
    logic [2:0] g;
    int         w;
    logic [3:0] a;
    if (!Reset) begin
      model_reset();
    end else begin
      g = exp_grant();
      if (g != 3'b000) begin
        w = (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : 2;
        a = bus.req_addr[w*AW +: AW];
        if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
        if (a < NREG) m_regs[a] = bus.req_data[w*W +: W];
        if (!m_locked) begin
          m_ptr = (w + 1) % NREQ;
          if (bus.req_lock[w]) begin m_locked = 1; m_owner = w; end
        end else if (!bus.req_lock[w]) begin
          m_locked = 0;
          m_ptr    = (w + 1) % NREQ;
        end
      end
      if (clear) begin
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
        m_locked = 0; m_cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("ready", bus.req_ready, exp_grant());
      chk("locked", locked, m_locked);
      chk("owner", owner, m_owner);
      chk("wr_count", wr_count, m_cnt);
      chk("rd_data", bus.rd_data, (bus.rd_addr < NREG) ? m_regs[bus.rd_addr] : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [3:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_lock[i]           = l;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*W +: W]    = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  logic [2:0] order_exp [4];

  initial begin
    model_reset();
    Reset = 1'b0;
    clear = 1'b0;
    bus.rd_addr = '0;
    idle_all();
    step(2);

    // Reset state.
    #1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_owner", owner, 3'd0);
    chk("rst_count", wr_count, 16'd0);
    chk("rst_rd", bus.rd_data, 32'd0);

    // Single write by req0.
    step(1);
    Reset  = 1'b1;
    chk_en = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'd2, 32'd1);
    bus.rd_addr = 4'd2;
    #1;
    chk("t1_ready", bus.req_ready, 3'b001);
    step(1);
    idle_all();
    #1;
    chk("t1_rd", bus.rd_data, 32'd1);
    chk("t1_count", wr_count, 16'd1);

    // req2 alone moves the pointer back to 0.
    set_req(2, 1'b1, 1'b0, 4'd5, 32'd77);
    #1;
    chk("t2_pre_ready", bus.req_ready, 3'b100);
    step(1);
    idle_all();

    // All three valid: rotation 0,1,2,0.
    order_exp[0] = 3'b001; order_exp[1] = 3'b010;
    order_exp[2] = 3'b100; order_exp[3] = 3'b001;
    set_req(0, 1'b1, 1'b0, 4'd0, 32'd11);
    set_req(1, 1'b1, 1'b0, 4'd1, 32'd20);
    set_req(2, 1'b1, 1'b0, 4'd2, 32'd1000);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr_order", bus.req_ready, order_exp[c]);
      chk("rr_count", wr_count, 16'(2 + c));
      step(1);
    end
    idle_all();
    chk("rr_count_end", wr_count, 16'd6);
    for (int r = 0; r < 3; r++) begin
      bus.rd_addr = 4'(r);
      #1;
      chk("rr_reg", bus.rd_data, (r == 0) ? 32'd11 : (r == 1) ? 32'd20 : 32'd1000);
    end

    // Lock by req1, others starved until the unlocking write.
    set_req(1, 1'b1, 1'b1, 4'd3, 32'd55);
    #1;
    chk("lk_ready", bus.req_ready, 3'b010);
    step(1);
    set_req(1, 1'b0, 1'b0, 4'd3, 32'd55);
    set_req(0, 1'b1, 1'b0, 4'd6, 32'd66);
    set_req(2, 1'b1, 1'b0, 4'd7, 32'd77);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) set_req(1, 1'b1, 1'b0, 4'd3, 32'd100);
      #1;
      chk("lk_hold_ready", bus.req_ready, (c == 2) ? 3'b010 : 3'b000);
      chk("lk_locked", locked, 1'b1);
      chk("lk_owner", owner, 3'd1);
      step(1);
    end
    set_req(1, 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    chk("unlk_locked", locked, 1'b0);
    chk("unlk_ready", bus.req_ready, 3'b100);
    step(1);
    set_req(2, 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    chk("unlk_next", bus.req_ready, 3'b001);
    step(1);
    idle_all();
    bus.rd_addr = 4'd3;
    #1;
    chk("unlk_reg3", bus.rd_data, 32'd100);
    chk("unlk_count", wr_count, 16'd10);

    // Clear beats a valid request.
    clear = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'd0, 32'd5);
    #1;
    chk("clr_ready", bus.req_ready, 3'b000);
    step(1);
    for (int r = 0; r < NREG; r++) begin
      bus.rd_addr = 4'(r);
      #1;
      chk("clr_rd", bus.rd_data, 32'd0);
    end
    chk("clr_count", wr_count, 16'd0);
    chk("clr_locked", locked, 1'b0);
    step(1);
    idle_all();
    clear = 1'b0;

    // Reset between edges while locked.
    set_req(0, 1'b1, 1'b1, 4'd1, 32'd9);
    bus.rd_addr = 4'd1;
    step(1);
    idle_all();
    set_req(2, 1'b1, 1'b0, 4'd4, 32'd44);
    #1;
    chk("mr_locked_pre", locked, 1'b1);
    chk("mr_rd_pre", bus.rd_data, 32'd9);
    chk("mr_ready_pre", bus.req_ready, 3'b000);
    #1;
    Reset = 1'b0;
    #1;
    chk("mr_locked", locked, 1'b0);
    chk("mr_count", wr_count, 16'd0);
    chk("mr_rd", bus.rd_data, 32'd0);
    step(1);
    Reset = 1'b1;
    #1;
    chk("mr_first_grant", bus.req_ready, 3'b100);
    step(1);
    idle_all();

    // Out-of-range write address.
    set_req(0, 1'b1, 1'b0, 4'd9, 32'hDEAD);
    #1;
    chk("oor_ready", bus.req_ready, 3'b001);
    step(1);
    idle_all();
    #1;
    chk("oor_count", wr_count, 16'd2);
    bus.rd_addr = 4'd9;
    #1;
    chk("oor_rd9", bus.rd_data, 32'd0);
    for (int r = 0; r < NREG; r++) begin
      bus.rd_addr = 4'(r);
      #1;
      chk("oor_reg", bus.rd_data, (r == 4) ? 32'd44 : 32'd0);
    end
    step(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
